// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared defaults, the write-buffer entry type and a clog2 helper
//             for the data-memory responder.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

    localparam int DMEM_ADDR_W     = 11;
    localparam int DMEM_DATA_W     = 32;
    localparam int DMEM_WBUF_DEPTH = 4;

    // One posted store at the default widths.
    typedef struct packed {
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] data;
    } wbuf_entry_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder_if
//  Purpose  : Load/store bus between the core (master) and the data-memory
//             responder (slave), plus write-buffer status.
//  Ports    : dmem_r, dmem_w, data_addr, w_data          core -> responder
//             dmem_data, wbuf_count, wbuf_empty,
//             wbuf_full, drop_err                        responder -> core
//             stat_loads, stat_stores, stat_fwd          only with DMEM_STATS_EN
//  Revision : 1.0  initial release
// ============================================================================
interface dmem_responder_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int WBUF_DEPTH = DMEM_WBUF_DEPTH
);
    localparam int CNT_W = clog2(WBUF_DEPTH) + 1;

    logic              dmem_r;
    logic              dmem_w;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] dmem_data;
    logic [CNT_W-1:0]  wbuf_count;
    logic              wbuf_empty;
    logic              wbuf_full;
    logic              drop_err;
`ifdef DMEM_STATS_EN
    logic [31:0]       stat_loads;
    logic [31:0]       stat_stores;
    logic [31:0]       stat_fwd;
`endif

    modport master (
        output dmem_r, dmem_w, data_addr, w_data,
        input  dmem_data, wbuf_count, wbuf_empty, wbuf_full, drop_err
`ifdef DMEM_STATS_EN
        , input stat_loads, stat_stores, stat_fwd
`endif
    );

    modport slave (
        input  dmem_r, dmem_w, data_addr, w_data,
        output dmem_data, wbuf_count, wbuf_empty, wbuf_full, drop_err
`ifdef DMEM_STATS_EN
        , output stat_loads, stat_stores, stat_fwd
`endif
    );

endinterface
`default_nettype wire

// File: rtl/dmem_responder_wbuf_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : wbuf_fifo
//  Purpose  : Posted-store FIFO with a parallel address match that returns
//             the youngest buffered data for a lookup address.
//  Ports    : clk, rstn                 clock / async active-low reset
//             push_i, addr_i, data_i    enqueue one {addr,data}
//             pop_i                     dequeue the head (only when not empty)
//             head_addr_o, head_data_o  oldest entry
//             count_o, empty_o, full_o  occupancy
//             lookup_addr_i, hit_o,
//             hit_data_o                forwarding match
//  Revision : 1.0  initial release
// ============================================================================
module wbuf_fifo
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = DMEM_WBUF_DEPTH,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  wire logic              clk,
    input  wire logic              rstn,
    input  wire logic              push_i,
    input  wire logic [ADDR_W-1:0] addr_i,
    input  wire logic [DATA_W-1:0] data_i,
    input  wire logic              pop_i,
    output logic      [ADDR_W-1:0] head_addr_o,
    output logic      [DATA_W-1:0] head_data_o,
    output logic      [CNT_W-1:0]  count_o,
    output logic                   empty_o,
    output logic                   full_o,
    input  wire logic [ADDR_W-1:0] lookup_addr_i,
    output logic                   hit_o,
    output logic      [DATA_W-1:0] hit_data_o
);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [PTR_W-1:0] scan_idx;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
        count_d  = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_q[wr_ptr_q] <= addr_i;
            data_q[wr_ptr_q] <= data_i;
        end
    end

    // Walk live entries oldest to youngest so the last match overrides.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        scan_idx   = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_q[scan_idx] == lookup_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = data_q[scan_idx];
            end
        end
    end

    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign count_o     = count_q;
    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CNT_W'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Data-memory side of the core load/store interface. Stores are
//             posted into a write buffer that drains into a single-port word
//             RAM whenever no load owns the port; loads forward from buffered
//             stores and return data combinationally.
//  Ports    : clk    clock, rising edge
//             rstn   asynchronous active-low reset
//             bus    dmem_responder_if.slave (requests, load data, status)
//  Config   : DMEM_STATS_EN adds stat_loads/stat_stores/stat_fwd counters.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int WBUF_DEPTH = DMEM_WBUF_DEPTH
) (
    input  wire logic         clk,
    input  wire logic         rstn,
    dmem_responder_if.slave   bus
);

    localparam int CNT_W = clog2(WBUF_DEPTH) + 1;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    logic              drain;
    logic              push_ok;
    logic              drop;
    logic              drop_err_q, drop_err_d;

    // A load owns the RAM port; the buffer drains only on load-free cycles.
    // A full buffer still accepts a store when the head leaves in the same
    // cycle; otherwise the store is discarded.
    assign drain   = !bus.dmem_r && !fifo_empty;
    assign push_ok = bus.dmem_w && (!fifo_full || drain);
    assign drop    = bus.dmem_w && fifo_full && !drain;

    wbuf_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (WBUF_DEPTH)
    ) u_wbuf (
        .clk           (clk),
        .rstn          (rstn),
        .push_i        (push_ok),
        .addr_i        (bus.data_addr),
        .data_i        (bus.w_data),
        .pop_i         (drain),
        .head_addr_o   (head_addr),
        .head_data_o   (head_data),
        .count_o       (fifo_count),
        .empty_o       (fifo_empty),
        .full_o        (fifo_full),
        .lookup_addr_i (bus.data_addr),
        .hit_o         (fwd_hit),
        .hit_data_o    (fwd_data)
    );

    always_ff @(posedge clk) begin
        if (drain) begin
            mem_q[head_addr] <= head_data;
        end
    end

    // Same-cycle store and load see the pre-store value: the push only
    // lands at the edge, after this combinational read.
    always_comb begin
        bus.dmem_data = '0;
        if (bus.dmem_r) begin
            bus.dmem_data = fwd_hit ? fwd_data : mem_q[bus.data_addr];
        end
    end

    assign drop_err_d = drop_err_q | drop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_err_q <= 1'b0;
        end else begin
            drop_err_q <= drop_err_d;
        end
    end

    assign bus.wbuf_count = fifo_count;
    assign bus.wbuf_empty = fifo_empty;
    assign bus.wbuf_full  = fifo_full;
    assign bus.drop_err   = drop_err_q;

`ifdef DMEM_STATS_EN
    logic [31:0] stat_loads_q,  stat_loads_d;
    logic [31:0] stat_stores_q, stat_stores_d;
    logic [31:0] stat_fwd_q,    stat_fwd_d;

    always_comb begin
        stat_loads_d  = stat_loads_q  + 32'(bus.dmem_r);
        stat_stores_d = stat_stores_q + 32'(push_ok);
        stat_fwd_d    = stat_fwd_q    + 32'(bus.dmem_r && fwd_hit);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_loads_q  <= '0;
            stat_stores_q <= '0;
            stat_fwd_q    <= '0;
        end else begin
            stat_loads_q  <= stat_loads_d;
            stat_stores_q <= stat_stores_d;
            stat_fwd_q    <= stat_fwd_d;
        end
    end

    assign bus.stat_loads  = stat_loads_q;
    assign bus.stat_stores = stat_stores_q;
    assign bus.stat_fwd    = stat_fwd_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Directed bench for dmem_responder. Load expectations are queued
//             when a load is issued and checked by a separate monitor on the
//             falling edge; status outputs are checked inline.
//  Config   : DMEM_STATS_EN enables the statistics checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    dmem_responder_if bus ();

    dmem_responder dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];
    logic [31:0] mon_exp;
    string       mon_tag;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Drive one cycle starting just after a rising edge; return just after the next one.
    task automatic step(input logic r, input logic w, input logic [10:0] a,
                        input logic [31:0] d, input logic [31:0] e, input string tag);
        bus.dmem_r    = r;
        bus.dmem_w    = w;
        bus.data_addr = a;
        bus.w_data    = d;
        if (r) begin
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 11'd0, 32'd0, 32'd0, "");
    endtask

    // Monitor: every load cycle consumes one expectation; idle cycles must read 0.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.dmem_r) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL load_unexpected: got 0x%08h expected no load", bus.dmem_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    mon_tag = tag_q.pop_front();
                    chk(mon_tag, bus.dmem_data, mon_exp);
                end
            end else begin
                chk("idle_data_zero", bus.dmem_data, 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    wbuf_entry_t prefill [$];

    initial begin
        bus.dmem_r    = 1'b0;
        bus.dmem_w    = 1'b0;
        bus.data_addr = '0;
        bus.w_data    = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 32'(bus.wbuf_count), 32'd0);
        chk("rst_empty", 32'(bus.wbuf_empty), 32'd1);
        chk("rst_full",  32'(bus.wbuf_full),  32'd0);
        chk("rst_drop",  32'(bus.drop_err),   32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Known RAM contents for later reads.
        prefill.push_back('{addr: 11'd1,  data: 32'hA1});
        prefill.push_back('{addr: 11'd2,  data: 32'hA2});
        prefill.push_back('{addr: 11'd3,  data: 32'hA3});
        for (int i = 0; i < 6; i++) prefill.push_back('{addr: 11'(20 + i), data: 32'hC0 + i});
        foreach (prefill[i]) step(1'b0, 1'b1, prefill[i].addr, prefill[i].data, 32'd0, "");
        idle(4);
        chk("prefill_empty", 32'(bus.wbuf_empty), 32'd1);
        step(1'b1, 1'b0, 11'd2, 32'd0, 32'hA2, "prefill_ram_2");

        // Forwarding of a single store, then drain into RAM.
        step(1'b0, 1'b1, 11'd5, 32'hDEADBEEF, 32'd0, "");
        step(1'b1, 1'b0, 11'd5, 32'd0, 32'hDEADBEEF, "fwd_addr5");
        chk("fwd_held_count", 32'(bus.wbuf_count), 32'd1);
        idle(2);
        chk("drain_empty", 32'(bus.wbuf_empty), 32'd1);
        step(1'b1, 1'b0, 11'd5, 32'd0, 32'hDEADBEEF, "ram_addr5");

        // Youngest match wins; same-cycle store+load returns pre-store value.
        step(1'b0, 1'b1, 11'd9, 32'h11, 32'd0, "");
        step(1'b1, 1'b1, 11'd9, 32'h22, 32'h11, "prestore_addr9");
        step(1'b1, 1'b0, 11'd9, 32'd0, 32'h22, "youngest_addr9");
        chk("two_buffered", 32'(bus.wbuf_count), 32'd2);
        idle(3);
        step(1'b1, 1'b0, 11'd9, 32'd0, 32'h22, "ram_order_addr9");

        // Fill with loads holding off the drain, then stores with drain while full.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 11'(20 + i), 32'hD0 + i, 32'hC0 + i, "fill_load");
        chk("fill_count", 32'(bus.wbuf_count), 32'd4);
        chk("fill_full",  32'(bus.wbuf_full),  32'd1);
        step(1'b0, 1'b1, 11'd24, 32'hD4, 32'd0, "");
        chk("full_push_pop_count", 32'(bus.wbuf_count), 32'd4);
        chk("full_push_pop_drop",  32'(bus.drop_err),   32'd0);
        step(1'b0, 1'b1, 11'd25, 32'hD5, 32'd0, "");
        step(1'b0, 1'b1, 11'd21, 32'hD7, 32'd0, "");
        chk("wrap_count", 32'(bus.wbuf_count), 32'd4);
        chk("wrap_drop",  32'(bus.drop_err),   32'd0);
        idle(4);
        chk("wrap_drained", 32'(bus.wbuf_empty), 32'd1);
        step(1'b1, 1'b0, 11'd20, 32'd0, 32'hD0, "order_20");
        step(1'b1, 1'b0, 11'd21, 32'd0, 32'hD7, "order_21_younger");
        step(1'b1, 1'b0, 11'd22, 32'd0, 32'hD2, "order_22");
        step(1'b1, 1'b0, 11'd23, 32'd0, 32'hD3, "order_23");
        step(1'b1, 1'b0, 11'd24, 32'd0, 32'hD4, "order_24");
        step(1'b1, 1'b0, 11'd25, 32'd0, 32'hD5, "order_25");

        // Full with a load in the same cycle: the store is dropped.
        step(1'b1, 1'b1, 11'd20, 32'hF0, 32'hD0, "drop_fill_20");
        step(1'b1, 1'b1, 11'd21, 32'hF1, 32'hD7, "drop_fill_21");
        step(1'b1, 1'b1, 11'd22, 32'hF2, 32'hD2, "drop_fill_22");
        step(1'b1, 1'b1, 11'd23, 32'hF3, 32'hD3, "drop_fill_23");
        step(1'b1, 1'b1, 11'd22, 32'h55, 32'hF2, "drop_cycle_fwd");
        chk("drop_count", 32'(bus.wbuf_count), 32'd4);
        chk("drop_err",   32'(bus.drop_err),   32'd1);
        step(1'b1, 1'b0, 11'd22, 32'd0, 32'hF2, "drop_not_stored");
        idle(4);
        chk("drop_sticky", 32'(bus.drop_err),   32'd1);
        chk("drop_drained", 32'(bus.wbuf_empty), 32'd1);
        step(1'b1, 1'b0, 11'd22, 32'd0, 32'hF2, "drop_ram_22");

        // Async reset with three stores still buffered.
        step(1'b1, 1'b1, 11'd1, 32'hB1, 32'hA1, "pre_reset_1");
        step(1'b1, 1'b1, 11'd2, 32'hB2, 32'hA2, "pre_reset_2");
        step(1'b1, 1'b1, 11'd3, 32'hB3, 32'hA3, "pre_reset_3");
        chk("pre_reset_count", 32'(bus.wbuf_count), 32'd3);
        bus.dmem_r = 1'b0;
        bus.dmem_w = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_count", 32'(bus.wbuf_count), 32'd0);
        chk("async_rst_empty", 32'(bus.wbuf_empty), 32'd1);
        chk("async_rst_drop",  32'(bus.drop_err),   32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        step(1'b0, 1'b1, 11'd30, 32'h30, 32'd0, "");
        step(1'b1, 1'b0, 11'd30, 32'd0, 32'h30, "stats_fwd_30");
        step(1'b0, 1'b1, 11'd31, 32'h31, 32'd0, "");
        step(1'b1, 1'b0, 11'd1, 32'd0, 32'hA1, "post_reset_1");
        step(1'b1, 1'b0, 11'd2, 32'd0, 32'hA2, "post_reset_2");
`ifdef DMEM_STATS_EN
        chk("stat_loads",  bus.stat_loads,  32'd3);
        chk("stat_stores", bus.stat_stores, 32'd2);
        chk("stat_fwd",    bus.stat_fwd,    32'd1);
`endif
        step(1'b1, 1'b0, 11'd3, 32'd0, 32'hA3, "post_reset_3");
        idle(2);
        chk("pending_loads", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
